// File: rtl/trdb_pkg.sv
// trdb_pkg - shared types and defaults for the trace debugger branch-map path.
//   BRANCH_MAP_LEN   default branch map capacity (bits)
//   BRANCH_COUNT_LEN width of a branch count able to hold BRANCH_MAP_LEN
//   N_RET_DEFAULT    default number of retirement lanes
//   trdb_bmap_pkt_t  {map, count, full} packet handed to the packet builder
//   trdb_ob_state_e  state of the single-entry output buffer
package trdb_pkg;

   localparam int BRANCH_MAP_LEN   = 30;
   localparam int BRANCH_COUNT_LEN = 5;
   localparam int N_RET_DEFAULT    = 2;

   typedef struct packed {
      logic [BRANCH_MAP_LEN-1:0]   map;
      logic [BRANCH_COUNT_LEN-1:0] count;
      logic                        full;
   } trdb_bmap_pkt_t;

   typedef enum logic {
      OB_EMPTY = 1'b0,
      OB_HOLD  = 1'b1
   } trdb_ob_state_e;

endpackage

// File: rtl/trdb_lane_compact.sv
// trdb_lane_compact - combinational per-lane prefix popcount.
// Gives each retirement lane the offset at which its branch bit is inserted
// behind the already accumulated bits, so non-contiguous valid lanes compact
// into a dense run in lane order.
//   valid_i   in  N_RET          per-lane valid (already gated by acceptance)
//   offset_o  out N_RET x OFF_W  number of valid lanes below each lane
//   k_o       out OFF_W          total number of valid lanes
module trdb_lane_compact #(
   parameter int N_RET = 2,
   parameter int OFF_W = $clog2(N_RET + 1)
) (
   input  logic [N_RET-1:0]            valid_i,
   output logic [N_RET-1:0][OFF_W-1:0] offset_o,
   output logic [OFF_W-1:0]            k_o
);

   logic [OFF_W-1:0] prefix [N_RET+1];

   assign prefix[0] = '0;

   generate
      for (genvar gi = 0; gi < N_RET; gi++) begin : g_lane
         assign prefix[gi+1]  = prefix[gi] + OFF_W'(valid_i[gi]);
         assign offset_o[gi]  = prefix[gi];
      end
   endgenerate

   assign k_o = prefix[N_RET];

endmodule

// File: rtl/trdb_branch_map_multi.sv
// trdb_branch_map_multi - multi-lane E-Trace branch map accumulator.
// Collects retired branch outcomes (1 = not taken) from up to N_RET lanes per
// cycle and emits {map, count, full} packets over a valid/ready handshake.
// Optional feature macro: TRDB_BMAP_TIMEOUT_EN (idle-flush counter).
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i/taken_i per-lane retired branch and its outcome, lane 0 oldest
//   flush_i        emit the current map now
//   in_ready_o     valid_i/flush_i consumed this cycle
//   timeout_i      idle-flush threshold, 0 disables (macro builds only)
//   out_valid_o/out_ready_i packet handshake
//   map_o, count_o, full_o  registered packet contents
module trdb_branch_map_multi
   import trdb_pkg::*;
#(
   parameter int MAP_LEN = BRANCH_MAP_LEN,
   parameter int N_RET   = N_RET_DEFAULT,
   parameter int CNT_LEN = $clog2(MAP_LEN + 1),
   parameter int TO_W    = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_RET-1:0]   valid_i,
   input  logic [N_RET-1:0]   taken_i,
   input  logic               flush_i,
   output logic               in_ready_o,
   input  logic [TO_W-1:0]    timeout_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [MAP_LEN-1:0] map_o,
   output logic [CNT_LEN-1:0] count_o,
   output logic               full_o
);

   localparam int OFF_W = $clog2(N_RET + 1);
   localparam int WIDE  = MAP_LEN + N_RET;
   localparam int TOT_W = $clog2(WIDE + 1);

   logic [MAP_LEN-1:0] acc_q, acc_d;
   logic [CNT_LEN-1:0] cnt_q, cnt_d;
   logic               pend_q, pend_d;
   trdb_ob_state_e     ob_q, ob_d;
   logic [MAP_LEN-1:0] map_q, map_d;
   logic [CNT_LEN-1:0] cnt_out_q, cnt_out_d;
   logic               full_q, full_d;

   logic                       in_ready;
   logic [N_RET-1:0]           lane_valid;
   logic [N_RET-1:0][OFF_W-1:0] offset;
   logic [OFF_W-1:0]           k;
   logic [WIDE-1:0]            wide;
   logic [TOT_W-1:0]           total;
   logic                       full_hit;
   logic                       flush_now;
   logic                       to_fire;
   logic                       emit;

   assign in_ready   = (ob_q == OB_EMPTY) | out_ready_i;
   assign lane_valid = valid_i & {N_RET{in_ready}};

   trdb_lane_compact #(
      .N_RET (N_RET),
      .OFF_W (OFF_W)
   ) u_compact (
      .valid_i  (lane_valid),
      .offset_o (offset),
      .k_o      (k)
   );

   // Accumulated bits plus this cycle's compacted bits, placed after the
   // current count. Bits above count are always zero in acc_q.
   always_comb begin
      wide = WIDE'(acc_q);
      for (int l = 0; l < N_RET; l++) begin
         if (lane_valid[l]) begin
            wide = wide | ({{(WIDE-1){1'b0}}, !taken_i[l]}
                           << (TOT_W'(cnt_q) + TOT_W'(offset[l])));
         end
      end
   end

   assign total     = TOT_W'(cnt_q) + TOT_W'(k);
   assign full_hit  = total >= TOT_W'(MAP_LEN);
   assign flush_now = in_ready & (flush_i | pend_q);

`ifdef TRDB_BMAP_TIMEOUT_EN
   logic [TO_W-1:0] idle_q, idle_d;

   // Fires on the idle cycle that brings the idle count up to the threshold.
   assign to_fire = in_ready && (cnt_q != '0) && (k == '0) && (timeout_i != '0)
                    && (({1'b0, idle_q} + (TO_W+1)'(1)) >= {1'b0, timeout_i});

   always_comb begin
      idle_d = idle_q;
      if (emit || (k != '0)) begin
         idle_d = '0;
      end else if ((cnt_q != '0) && (idle_q != '1)) begin
         idle_d = idle_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_i;
   assign to_fire        = 1'b0;
`endif

   // Emit priority: a full map first, then an explicit/pending flush, then idle timeout.
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      map_d     = map_q;
      cnt_out_d = cnt_out_q;
      full_d    = full_q;
      emit      = 1'b0;
      if (full_hit) begin
         emit      = 1'b1;
         map_d     = wide[MAP_LEN-1:0];
         cnt_out_d = CNT_LEN'(MAP_LEN);
         full_d    = 1'b1;
         acc_d     = MAP_LEN'(wide >> MAP_LEN);
         cnt_d     = CNT_LEN'(total - TOT_W'(MAP_LEN));
         // A flush colliding with a full map is deferred to the next accepting cycle.
         pend_d    = flush_now;
      end else if (flush_now || to_fire) begin
         emit      = 1'b1;
         map_d     = wide[MAP_LEN-1:0];
         cnt_out_d = CNT_LEN'(total);
         full_d    = 1'b0;
         acc_d     = '0;
         cnt_d     = '0;
         pend_d    = 1'b0;
      end else begin
         acc_d = wide[MAP_LEN-1:0];
         cnt_d = CNT_LEN'(total);
      end
   end

   always_comb begin
      ob_d = ob_q;
      unique case (ob_q)
         OB_EMPTY: if (emit) ob_d = OB_HOLD;
         OB_HOLD:  if (out_ready_i && !emit) ob_d = OB_EMPTY;
         default:  ob_d = OB_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         ob_q      <= OB_EMPTY;
         map_q     <= '0;
         cnt_out_q <= '0;
         full_q    <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         ob_q      <= ob_d;
         map_q     <= map_d;
         cnt_out_q <= cnt_out_d;
         full_q    <= full_d;
      end
   end

   assign in_ready_o  = in_ready;
   assign out_valid_o = (ob_q == OB_HOLD);
   assign map_o       = map_q;
   assign count_o     = cnt_out_q;
   assign full_o      = full_q;

endmodule
